wb_initiator: RTL and testbench
===============================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles in BUS state awaiting ack/err (legal 2..65535).
REQ-002 SHALL have port wb_clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  1  core request valid.
REQ-005 SHALL have port req_ready_o  output  1  bridge can accept request.
REQ-006 SHALL have port req_we_i  input  1  1=write, 0=read.
REQ-007 SHALL have port req_addr_i  input  32  byte address.
REQ-008 SHALL have port req_wdata_i  input  32  write data.
REQ-009 SHALL have port req_be_i  input  4  byte enables.
REQ-010 SHALL have port resp_valid_o  output  1  one-cycle response pulse.
REQ-011 SHALL have port resp_rdata_o  output  32  read data.
REQ-012 SHALL have port resp_err_o  output  1  bus error or timeout, qualified by resp_valid_o.
REQ-013 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone classic cycle/strobe/write.
REQ-014 SHALL have ports wb_adr_o  output  32, wb_dat_o  output  32, wb_sel_o  output  4  Wishbone address/data/select.
REQ-015 SHALL have ports wb_dat_i  input  32, wb_ack_i  input  1, wb_err_i  input  1  responder data/ack/error.

Function
REQ-016 SHALL implement FSM states IDLE, BUS, RESP; one outstanding transaction maximum.
REQ-017 SHALL drive req_ready_o=1 only in IDLE, combinationally from state.
REQ-018 SHALL, in IDLE with req_valid_i=1, register we/addr/wdata/be into hold registers and enter BUS next edge.
REQ-019 SHALL, in BUS, drive wb_cyc_o=wb_stb_o=1 and wb_we_o/wb_adr_o/wb_dat_o/wb_sel_o from hold registers, all stable until termination.
REQ-020 SHALL drive wb_cyc_o=wb_stb_o=0 outside BUS; wb_dat_o/wb_adr_o/wb_sel_o SHALL hold last values (don't-care to responder).
REQ-021 SHALL terminate BUS on the first edge where wb_ack_i or wb_err_i is 1 (zero-wait-state combinational ack supported), entering RESP.
REQ-022 SHALL, on ack with we=0, register wb_dat_i into resp_rdata_o; on write, resp_rdata_o=0.
REQ-023 SHALL, when wb_ack_i and wb_err_i are both 1, treat as error: resp_err_o=1, resp_rdata_o=0.
REQ-024 SHALL count cycles spent in BUS (16-bit counter, cleared on BUS entry); if count reaches TIMEOUT-1 with no ack/err, SHALL terminate with resp_err_o=1, resp_rdata_o=0, and deassert wb_cyc_o next cycle.
REQ-025 SHALL, in RESP, assert resp_valid_o=1 for exactly one cycle then return to IDLE; no response backpressure.
REQ-026 SHALL ignore wb_ack_i/wb_err_i outside BUS (no state or output change).
REQ-027 Latency: request accepted edge N, wb_stb_o high cycle N+1, ack in cycle N+k, resp_valid_o high cycle N+k+1; minimum 2 cycles request-to-response.
REQ-028 SHALL not sample req_* outside IDLE; changes there have no effect.

Reset
REQ-029 SHALL, while wb_rst_i=1, force state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, counter=0.
REQ-030 SHALL, on reset asserted mid-BUS, drop wb_cyc_o immediately (asynchronous) and emit no response after reset release.
REQ-031 SHALL have req_ready_o=1 on the first cycle after reset release.

Verification
REQ-032 Read, zero-wait responder: addr 0x20000C08, responder acks same cycle with 0x0000_1234 -> one stb cycle, resp_valid_o 2 cycles after accept, rdata 0x0000_1234, err 0.
REQ-033 Write with 3 wait states: addr 0x20000C00, wdata 0xDEADBEEF, be 0xF -> cyc/stb/adr/dat/sel stable 4 cycles, resp_valid_o next cycle, err 0, rdata 0.
REQ-034 Error: responder asserts wb_ack_i and wb_err_i together on read -> resp_err_o=1, resp_rdata_o=0.
REQ-035 Timeout: TIMEOUT=8, responder never acks -> wb_stb_o high exactly 8 cycles, resp_valid_o with resp_err_o=1, wb_cyc_o low afterwards, req_ready_o high cycle after response.
REQ-036 Reset mid-BUS: assert wb_rst_i during wait state -> wb_cyc_o=0 same cycle, no resp_valid_o after release, next request completes normally.
REQ-037 Back-to-back: req_valid_i held with two requests -> second accepted only in IDLE after first resp_valid_o; stray wb_ack_i in IDLE ignored.

Source files
------------

// File: rtl/wb_initiator_if.sv
// Core request/response channel plus Wishbone classic bus, grouped for the bridge.
// The master modport is the bridge's view; the slave modport is the core/responder environment.
interface wb_initiator_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding core-to-Wishbone-classic bridge; response 1 cycle after ack/err/timeout (min 2 from accept).
// Backpressure: req_ready_o only in IDLE; responses are a one-cycle pulse with no backpressure.
module wb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        load;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Error wins over ack; a responder termination in the last counted cycle wins over timeout.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          load    = 1'b1;
          cnt_d   = 16'd0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus.wb_err_i) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = RESP;
        end else if (bus.wb_ack_i) begin
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : bus.wb_dat_i;
          state_d = RESP;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      cnt_q   <= 16'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (load) begin
        we_q  <= bus.req_we_i;
        adr_q <= bus.req_addr_i;
        dat_q <= bus.req_wdata_i;
        sel_q <= bus.req_be_i;
      end
    end
  end

  // Bus outputs come straight from hold registers so they keep their last value outside BUS.
  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.wb_cyc_o     = (state_q == BUS);
  assign bus.wb_stb_o     = (state_q == BUS);
  assign bus.wb_we_o      = we_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_dat_o     = dat_q;
  assign bus.wb_sel_o     = sel_q;
  assign bus.resp_valid_o = (state_q == RESP);
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized bench for wb_initiator against a per-transaction outcome model (TIMEOUT=8).
module tb_wb_initiator;

  localparam int T         = 8;
  localparam int MODE_ACK  = 0;
  localparam int MODE_ERR  = 1;
  localparam int MODE_BOTH = 2;
  localparam int MODE_NONE = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  wb_initiator_if bus();

  wb_initiator #(.TIMEOUT(T)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: terminates in the stb cycle whose index (from 0) equals rsp_wait.
  int          rsp_mode;
  int          rsp_wait;
  logic [31:0] rsp_data;
  logic        stray_ack;
  int          stb_cnt;

  always @(posedge clk) stb_cnt <= bus.wb_stb_o ? stb_cnt + 1 : 0;

  assign bus.wb_ack_i = stray_ack ||
                        (bus.wb_stb_o && (rsp_mode == MODE_ACK || rsp_mode == MODE_BOTH) && stb_cnt == rsp_wait);
  assign bus.wb_err_i = bus.wb_stb_o && (rsp_mode == MODE_ERR || rsp_mode == MODE_BOTH) && stb_cnt == rsp_wait;
  assign bus.wb_dat_i = bus.wb_stb_o ? rsp_data : 32'hBAD0_0BAD;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_rsp(input int mode, input int w, input logic [31:0] d);
    rsp_mode = mode;
    rsp_wait = w;
    rsp_data = d;
  endtask

  // Presents a request in IDLE, returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic t_we, input logic [31:0] t_a, input logic [31:0] t_d,
                       input logic [3:0] t_be, input bit keep_valid);
    @(negedge clk);
    bus.req_we_i    = t_we;
    bus.req_addr_i  = t_a;
    bus.req_wdata_i = t_d;
    bus.req_be_i    = t_be;
    bus.req_valid_i = 1'b1;
    check_eq("ready_before_accept", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) bus.req_valid_i = 1'b0;
  endtask

  // Reference outcome from the transaction rules: responder term vs. timeout, error precedence.
  task automatic observe(input string tag, input logic t_we, input logic [31:0] t_a,
                         input logic [31:0] t_d, input logic [3:0] t_be,
                         input int mode, input int w, input logic [31:0] rdat, input bit scramble);
    bit          term;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          got_lat;
    int          stbn;
    int          bad;
    term    = (mode != MODE_NONE) && (w <= T - 1);
    exp_err = !term || (mode != MODE_ACK);
    exp_rd  = exp_err ? 32'd0 : (t_we ? 32'd0 : rdat);
    exp_lat = (term ? w : T - 1) + 2;
    got_lat = 0;
    stbn    = 0;
    bad     = 0;
    for (int i = 1; i <= 60; i++) begin
      if (scramble) begin
        bus.req_we_i    = 1'($urandom);
        bus.req_addr_i  = $urandom;
        bus.req_wdata_i = $urandom;
        bus.req_be_i    = 4'($urandom);
      end
      if (bus.wb_stb_o) begin
        stbn++;
        if (!bus.wb_cyc_o || bus.wb_adr_o !== t_a || bus.wb_dat_o !== t_d ||
            bus.wb_sel_o !== t_be || bus.wb_we_o !== t_we || bus.req_ready_o) bad++;
      end
      if (bus.resp_valid_o) begin
        got_lat = i;
        check_eq({tag, "_rdata"}, bus.resp_rdata_o, exp_rd);
        check_eq({tag, "_err"}, 32'(bus.resp_err_o), 32'(exp_err));
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
    check_eq({tag, "_stb_cycles"}, 32'(stbn), 32'(exp_lat - 1));
    check_eq({tag, "_bus_unstable"}, 32'(bad), 32'd0);
    @(negedge clk);
    check_eq({tag, "_resp_one_cycle"}, 32'(bus.resp_valid_o), 32'd0);
    check_eq({tag, "_ready_after"}, 32'(bus.req_ready_o), 32'd1);
    check_eq({tag, "_cyc_after"}, 32'(bus.wb_cyc_o), 32'd0);
  endtask

  task automatic txn(input string tag, input logic t_we, input logic [31:0] t_a,
                     input logic [31:0] t_d, input logic [3:0] t_be,
                     input int mode, input int w, input logic [31:0] rdat);
    set_rsp(mode, w, rdat);
    issue(t_we, t_a, t_d, t_be, 1'b0);
    observe(tag, t_we, t_a, t_d, t_be, mode, w, rdat, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int bad;
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    stray_ack = 1'b0;
    set_rsp(MODE_NONE, 0, 32'd0);
    bus.req_valid_i = 1'b0;
    bus.req_we_i = 1'b0;
    bus.req_addr_i = 32'd0;
    bus.req_wdata_i = 32'd0;
    bus.req_be_i = 4'd0;

    repeat (3) @(negedge clk);
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    check_eq("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    check_eq("rst_we", 32'(bus.wb_we_o), 32'd0);
    check_eq("rst_adr", bus.wb_adr_o, 32'd0);
    check_eq("rst_dat", bus.wb_dat_o, 32'd0);
    check_eq("rst_sel", 32'(bus.wb_sel_o), 32'd0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check_eq("rst_resp_err", 32'(bus.resp_err_o), 32'd0);
    check_eq("rst_resp_rdata", bus.resp_rdata_o, 32'd0);
    bus.req_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("ready_after_release", 32'(bus.req_ready_o), 32'd1);

    txn("zero_wait_read", 1'b0, 32'h2000_0C08, 32'h0, 4'hF, MODE_ACK, 0, 32'h0000_1234);
    txn("write_3ws", 1'b1, 32'h2000_0C00, 32'hDEAD_BEEF, 4'hF, MODE_ACK, 3, 32'h5555_AAAA);
    txn("ack_and_err", 1'b0, 32'h2000_0C10, 32'h0, 4'h3, MODE_BOTH, 1, 32'hCAFE_F00D);
    txn("err_only", 1'b1, 32'h2000_0C14, 32'h1111_2222, 4'h1, MODE_ERR, 2, 32'h0);
    txn("timeout", 1'b0, 32'h2000_0C20, 32'h0, 4'hF, MODE_NONE, 0, 32'h7777_7777);
    txn("ack_last_cycle", 1'b0, 32'h2000_0C24, 32'h0, 4'hF, MODE_ACK, T - 1, 32'h0BAD_CAFE);
    txn("ack_too_late", 1'b0, 32'h2000_0C28, 32'h0, 4'hF, MODE_ACK, T, 32'h1357_9BDF);

    // Reset during a wait state: cyc must fall asynchronously, no response afterwards.
    set_rsp(MODE_NONE, 0, 32'h0);
    issue(1'b0, 32'h2000_0C30, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midbus_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    check_eq("midbus_rst_stb", 32'(bus.wb_stb_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o || !bus.req_ready_o) bad++;
    end
    check_eq("midbus_rst_no_resp", 32'(bad), 32'd0);
    txn("after_rst", 1'b0, 32'h2000_0C34, 32'h0, 4'hC, MODE_ACK, 2, 32'hA5A5_5A5A);

    // Back-to-back with req_valid held: second request waits for the first response.
    set_rsp(MODE_ACK, 2, 32'h0102_0304);
    issue(1'b0, 32'h2000_0C40, 32'h0, 4'hF, 1'b1);
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 32'h2000_0C44;
    bus.req_wdata_i = 32'h0A0B_0C0D;
    bus.req_be_i    = 4'h6;
    observe("b2b_first", 1'b0, 32'h2000_0C40, 32'h0, 4'hF, MODE_ACK, 2, 32'h0102_0304, 1'b0);
    set_rsp(MODE_ACK, 1, 32'h0);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    observe("b2b_second", 1'b1, 32'h2000_0C44, 32'h0A0B_0C0D, 4'h6, MODE_ACK, 1, 32'h0, 1'b0);

    // Stray ack while idle changes nothing.
    bad = 0;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o || !bus.req_ready_o || bus.wb_cyc_o) bad++;
    end
    stray_ack = 1'b0;
    @(negedge clk);
    if (bus.resp_valid_o || !bus.req_ready_o) bad++;
    check_eq("stray_ack_ignored", 32'(bad), 32'd0);

    for (int n = 0; n < 40; n++) begin
      txn("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, T + 2)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
